// File: rtl/handshake_rr_merge.sv
// handshake_rr_merge: shares one registered output channel among NUM_INPUTS
// valid/ready requesters using round-robin arbitration.
// The output stage holds one token (EMPTY / FULL). It can drain and refill in
// the same cycle, so it sustains one transfer per cycle when outs_ready is high.
// Optional feature: define HANDSHAKE_RR_MERGE_INDEX_EN to add the outs_index
// port. This port reports which requester produced the buffered token.
module handshake_rr_merge #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_INPUTS = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] ins,
    input  logic [NUM_INPUTS-1:0]            ins_valid,
    output logic [NUM_INPUTS-1:0]            ins_ready,
    output logic [DATA_WIDTH-1:0]            outs,
    output logic                             outs_valid,
    input  logic                             outs_ready
`ifdef HANDSHAKE_RR_MERGE_INDEX_EN
    ,
    output logic [$clog2(NUM_INPUTS)-1:0]    outs_index
`endif
);

    localparam int PTR_W = $clog2(NUM_INPUTS);

    logic [DATA_WIDTH-1:0] outs_reg;
    logic                  outs_valid_reg;
    logic [PTR_W-1:0]      ptr_reg;
    logic [PTR_W-1:0]      ptr_next;

    logic [DATA_WIDTH-1:0] ins_arr [NUM_INPUTS];
    logic                  accept;
    logic                  grant_found;
    logic [PTR_W-1:0]      grant_idx;
    logic [PTR_W:0]        scan_pos;
    logic [PTR_W-1:0]      scan_idx;

    // Split the flat input bus into one word per requester.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_unpack
            assign ins_arr[gi] = ins[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // The output register can take a new token when it is empty or is draining now.
    assign accept = ~outs_valid_reg | outs_ready;

    // Round-robin search: the first valid requester at ptr, ptr+1, ... (wrapping).
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_pos    = '0;
        scan_idx    = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            scan_pos = {1'b0, ptr_reg} + (PTR_W+1)'(k);
            if (scan_pos >= (PTR_W+1)'(NUM_INPUTS)) begin
                scan_pos = scan_pos - (PTR_W+1)'(NUM_INPUTS);
            end
            scan_idx = scan_pos[PTR_W-1:0];
            if (!grant_found && ins_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    // After a grant, the requester following the winner gets priority; wrap to 0 after the last one.
    assign ptr_next = (grant_idx == PTR_W'(NUM_INPUTS - 1)) ? '0 : grant_idx + PTR_W'(1);

    // One-hot ready to the winner. Reset forces all ready bits low, whatever clk is doing.
    generate
        for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_ready
            assign ins_ready[gi] = rst & accept & grant_found & (grant_idx == PTR_W'(gi));
        end
    endgenerate

    // Output register and priority pointer. Both change only when the output register accepts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outs_reg       <= '0;
            outs_valid_reg <= 1'b0;
            ptr_reg        <= '0;
        end else if (accept) begin
            if (grant_found) begin
                outs_reg       <= ins_arr[grant_idx];
                outs_valid_reg <= 1'b1;
                ptr_reg        <= ptr_next;
            end else begin
                outs_valid_reg <= 1'b0;
            end
        end
    end

    assign outs       = outs_reg;
    assign outs_valid = outs_valid_reg;

`ifdef HANDSHAKE_RR_MERGE_INDEX_EN
    logic [PTR_W-1:0] outs_index_reg;

    // Source index of the buffered token. It loads with outs and holds while stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outs_index_reg <= '0;
        end else if (accept && grant_found) begin
            outs_index_reg <= grant_idx;
        end
    end

    assign outs_index = outs_index_reg;
`endif

endmodule

// File: tb/tb_handshake_rr_merge.sv
// Testbench for handshake_rr_merge (DATA_WIDTH=32, NUM_INPUTS=4).
// Runs directed scenarios with literal expectations, then randomized traffic.
// A reference model is compared against the DUT on every falling clock edge.
// Define HANDSHAKE_RR_MERGE_INDEX_EN to also check outs_index.
module tb_handshake_rr_merge;

    localparam int W = 32;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N*W-1:0] ins = '0;
    logic [N-1:0]   ins_valid = '0;
    logic [N-1:0]   ins_ready;
    logic [W-1:0]   outs;
    logic           outs_valid;
    logic           outs_ready = 1'b0;
`ifdef HANDSHAKE_RR_MERGE_INDEX_EN
    logic [1:0]     outs_index;
`endif

    int checks = 0;
    int errors = 0;

    handshake_rr_merge #(.DATA_WIDTH(W), .NUM_INPUTS(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .ins        (ins),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .outs       (outs),
        .outs_valid (outs_valid),
        .outs_ready (outs_ready)
`ifdef HANDSHAKE_RR_MERGE_INDEX_EN
        ,
        .outs_index (outs_index)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: the one-entry output buffer and the priority pointer.
    logic [W-1:0] m_data  = '0;
    logic         m_valid = 1'b0;
    int           m_ptr   = 0;
    int           m_idx   = 0;

    // The winner is the valid requester closest to ptr, going forward around the ring. Returns -1 if none.
    function automatic int pick(input logic [N-1:0] v, input int p);
        int best  = -1;
        int bestd = N;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                int d = (i - p + N) % N;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_data  <= '0;
            m_valid <= 1'b0;
            m_ptr   <= 0;
            m_idx   <= 0;
        end else if (!m_valid || outs_ready) begin
            int g;
            g = pick(ins_valid, m_ptr);
            if (g >= 0) begin
                m_data  <= ins[g*W +: W];
                m_valid <= 1'b1;
                m_ptr   <= (g + 1) % N;
                m_idx   <= g;
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process: on each falling edge, check the DUT outputs against the model.
    always @(negedge clk) begin
        logic [N-1:0] exp_ready;
        int g;
        exp_ready = '0;
        g = pick(ins_valid, m_ptr);
        if (rst && (!m_valid || outs_ready) && g >= 0) exp_ready[g] = 1'b1;
        chk("model_ins_ready", 32'(ins_ready), 32'(exp_ready));
        chk("model_outs_valid", 32'(outs_valid), 32'(m_valid));
        chk("model_outs", outs, m_data);
`ifdef HANDSHAKE_RR_MERGE_INDEX_EN
        chk("model_outs_index", 32'(outs_index), 32'(m_idx));
`endif
        if (rst && outs_valid && outs_ready)
            $display("xfer t=%0t data=%h", $time, outs);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) ins[i*W +: W] = 32'h100 + 32'(i);
        ins_valid  = 4'b1111;
        outs_ready = 1'b1;

        // Reset is held with every requester valid.
        #3;
        chk("rst_valid", 32'(outs_valid), 32'd0);
        chk("rst_outs", outs, 32'd0);
        chk("rst_ready", 32'(ins_ready), 32'd0);
        step();
        step();
        chk("rst_ready_clk", 32'(ins_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("first_grant", 32'(ins_ready), 32'b0001);

        // Round-robin with all four requesters valid.
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rr_outs", outs, 32'h100 + 32'(k % 4));
            chk("rr_valid", 32'(outs_valid), 32'd1);
            chk("rr_ready", 32'(ins_ready), 32'(1 << ((k + 1) % 4)));
`ifdef HANDSHAKE_RR_MERGE_INDEX_EN
            chk("rr_index", 32'(outs_index), 32'(k % 4));
`endif
        end

        // Stall with 0x101 buffered.
        step();
        chk("pre_stall_outs", outs, 32'h101);
        outs_ready = 1'b0;
        #1;
        chk("stall_ready0", 32'(ins_ready), 32'd0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stall_outs", outs, 32'h101);
            chk("stall_valid", 32'(outs_valid), 32'd1);
            chk("stall_ready", 32'(ins_ready), 32'd0);
        end
        outs_ready = 1'b1;
        #1;
        chk("unstall_ready", 32'(ins_ready), 32'b0100);
        step();
        chk("unstall_outs", outs, 32'h102);

        // Sparse requests wrapping from ptr=3.
        ins_valid = 4'b0101;
        #1;
        chk("sparse_ready_a", 32'(ins_ready), 32'b0001);
        step();
        chk("sparse_outs_a", outs, 32'h100);
        chk("sparse_ready_b", 32'(ins_ready), 32'b0100);
        step();
        chk("sparse_outs_b", outs, 32'h102);

        // Drain with no requesters.
        ins_valid = 4'b0000;
        #1;
        chk("drain_ready", 32'(ins_ready), 32'd0);
        step();
        chk("drain_valid", 32'(outs_valid), 32'd0);
        chk("drain_outs", outs, 32'h102);
        step();
        chk("drain_valid2", 32'(outs_valid), 32'd0);

        // Assert reset mid-stream while ptr is nonzero.
        ins_valid = 4'b1111;
        step();
        chk("pre_rst_outs_a", outs, 32'h103);
        step();
        chk("pre_rst_outs_b", outs, 32'h100);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(outs_valid), 32'd0);
        chk("mid_rst_outs", outs, 32'd0);
        chk("mid_rst_ready", 32'(ins_ready), 32'd0);
`ifdef HANDSHAKE_RR_MERGE_INDEX_EN
        chk("mid_rst_index", 32'(outs_index), 32'd0);
`endif
        step();
        rst = 1'b1;
        #1;
        chk("post_rst_grant", 32'(ins_ready), 32'b0001);

        // Randomized traffic, checked by the compare process.
        for (int c = 0; c < 400; c++) begin
            step();
            ins_valid  = 4'($urandom);
            outs_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < N; i++) ins[i*W +: W] = $urandom;
            if ($urandom_range(0, 99) == 0) rst = 1'b0;
            else rst = 1'b1;
        end
        rst = 1'b1;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
